// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with bus request, ACK check and timeout
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int SETUP_CYCLES   = 200,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       rx_block,
   output logic       done,
   output logic       ack_err,
   output logic       timeout_err
);
   localparam int PMAX = INHIBIT_CYCLES > SETUP_CYCLES ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int PW = $clog2(PMAX + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE, DONE} state_t;

   state_t        state, state_n;
   logic [1:0]    clk_sync, data_sync;
   logic          clk_prev;
   logic          fall;
   logic [PW-1:0] phase_cnt, phase_cnt_n;
   logic [TW-1:0] tmo_cnt, tmo_cnt_n, tmo_inc;
   logic          tmo_hit;
   logic [9:0]    shift, shift_n;
   logic [3:0]    edge_cnt, edge_cnt_n;
   logic          ack_bit, ack_bit_n;
   logic          data_oe_n, done_n, ack_err_n, timeout_err_n;

   // two-flop synchronizers on both lines plus one history stage for clock falling-edge detection
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
         clk_prev  <= clk_sync[1];
      end

   assign fall    = clk_prev & ~clk_sync[1];
   assign tmo_hit = tmo_cnt == TW'(TIMEOUT_CYCLES);
   assign tmo_inc = tmo_hit ? tmo_cnt : tmo_cnt + 1'b1;

   // next-state and next-output logic; a device edge always beats the timeout terminal count
   always_comb begin
      state_n       = state;
      phase_cnt_n   = phase_cnt;
      tmo_cnt_n     = tmo_cnt;
      shift_n       = shift;
      edge_cnt_n    = edge_cnt;
      ack_bit_n     = ack_bit;
      data_oe_n     = ps2_data_oe;
      done_n        = 1'b0;
      ack_err_n     = 1'b0;
      timeout_err_n = 1'b0;
      case (state)
         IDLE:
            if (tx_valid & tx_ready) begin
               state_n     = INHIBIT;
               phase_cnt_n = '0;
               shift_n     = {1'b1, ~^tx_data, tx_data};
            end
         INHIBIT:
            if (phase_cnt == PW'(INHIBIT_CYCLES - 1)) begin
               state_n     = REQUEST;
               phase_cnt_n = '0;
               data_oe_n   = 1'b1;
            end else
               phase_cnt_n = phase_cnt + 1'b1;
         REQUEST:
            if (phase_cnt == PW'(SETUP_CYCLES - 1)) begin
               state_n    = SEND;
               tmo_cnt_n  = '0;
               edge_cnt_n = '0;
            end else
               phase_cnt_n = phase_cnt + 1'b1;
         SEND:
            if (fall) begin
               tmo_cnt_n  = '0;
               data_oe_n  = ~shift[0];
               shift_n    = {1'b1, shift[9:1]};
               edge_cnt_n = edge_cnt + 1'b1;
               state_n    = edge_cnt == 4'd9 ? ACK : SEND;
            end else if (tmo_hit) begin
               state_n       = IDLE;
               data_oe_n     = 1'b0;
               timeout_err_n = 1'b1;
            end else
               tmo_cnt_n = tmo_inc;
         ACK:
            if (fall) begin
               tmo_cnt_n = '0;
               ack_bit_n = data_sync[1];
               state_n   = WAIT_IDLE;
            end else if (tmo_hit) begin
               state_n       = IDLE;
               timeout_err_n = 1'b1;
            end else
               tmo_cnt_n = tmo_inc;
         WAIT_IDLE:
            if (clk_sync[1] & data_sync[1]) begin
               state_n   = DONE;
               done_n    = 1'b1;
               ack_err_n = ack_bit;
            end else if (fall)
               tmo_cnt_n = '0;
            else if (tmo_hit) begin
               state_n       = IDLE;
               timeout_err_n = 1'b1;
            end else
               tmo_cnt_n = tmo_inc;
         DONE:
            state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
      data_oe_n = data_oe_n & (state_n == REQUEST || state_n == SEND);
   end

   // state, datapath and registered outputs; reset releases both lines immediately
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= IDLE;
         phase_cnt   <= '0;
         tmo_cnt     <= '0;
         shift       <= '0;
         edge_cnt    <= '0;
         ack_bit     <= 1'b0;
         tx_ready    <= 1'b1;
         rx_block    <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         ack_err     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         phase_cnt   <= phase_cnt_n;
         tmo_cnt     <= tmo_cnt_n;
         shift       <= shift_n;
         edge_cnt    <= edge_cnt_n;
         ack_bit     <= ack_bit_n;
         tx_ready    <= state_n == IDLE;
         rx_block    <= state_n != IDLE;
         ps2_clk_oe  <= state_n == INHIBIT || state_n == REQUEST;
         ps2_data_oe <= data_oe_n;
         done        <= done_n;
         ack_err     <= ack_err_n;
         timeout_err <= timeout_err_n;
      end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed checks of the PS/2 host transmitter against a clocking device model
module tb_ps2_host_tx;
   localparam int HALF = 40;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic tx_valid = 1'b0;
   logic tx_ready, ps2_clk_oe, ps2_data_oe, rx_block, done, ack_err, timeout_err;
   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;
   logic watch_rx = 1'b0;
   wire  clk_line  = ~(ps2_clk_oe | dev_clk_low);
   wire  data_line = ~(ps2_data_oe | dev_data_low);

   int checks = 0, errors = 0;
   int done_cnt = 0, ackerr_cnt = 0, tmo_cnt = 0, stray_ack = 0, acc_cnt = 0, rx_drop = 0;
   int done_at_rel = 0;

   ps2_host_tx #(.INHIBIT_CYCLES(20), .SETUP_CYCLES(4), .TIMEOUT_CYCLES(500)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .ps2_clk_in(clk_line), .ps2_data_in(data_line), .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe), .rx_block(rx_block), .done(done), .ack_err(ack_err),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (ack_err) ackerr_cnt++;
      if (ack_err && !done) stray_ack++;
      if (timeout_err) tmo_cnt++;
      if (watch_rx && !rx_block) rx_drop++;
   end

   always @(posedge clk) if (tx_valid && tx_ready && !reset) acc_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_start(input logic [7:0] b, input bit keep);
      int n = 0;
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (tx_ready && n < 10);
      check("accept", tx_ready, 0);
      if (!keep) tx_valid = 1'b0;
   endtask

   task automatic dev_run(input int edges, input bit ack, input int hold,
                          output logic [10:0] bits, output int oe_hi, output int req_hi);
      int n = 0;
      bits = '0;
      oe_hi = 0;
      req_hi = 0;
      while (!ps2_clk_oe && n < 1000) begin
         @(negedge clk);
         n++;
      end
      while (ps2_clk_oe && oe_hi < 1000) begin
         oe_hi++;
         if (ps2_data_oe) req_hi++;
         @(negedge clk);
      end
      tick(HALF);
      bits[0] = data_line;
      for (int k = 1; k <= edges && k <= 10; k++) begin
         dev_clk_low = 1'b1;
         tick(HALF);
         bits[k] = data_line;
         dev_clk_low = 1'b0;
         tick(HALF);
      end
      if (edges >= 11) begin
         dev_data_low = !ack;
         tick(5);
         dev_clk_low = 1'b1;
         tick(HALF);
         dev_clk_low = 1'b0;
         tick(hold);
         done_at_rel = done_cnt;
         dev_data_low = 1'b0;
      end
   endtask

   task automatic end_frame(input string tag, input bit exp_ack);
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_lat"}, n, 3);
      check({tag, "_ack_err"}, ack_err, exp_ack);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_ready"}, tx_ready, 1);
   endtask

   initial begin
      logic [10:0] bits;
      int hi, rq, n, d0, t0, a0;
      tick(3);
      check("rst_ready", tx_ready, 1);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_rx_block", rx_block, 0);
      check("rst_done", done, 0);
      check("rst_ack_err", ack_err, 0);
      check("rst_timeout", timeout_err, 0);
      reset = 1'b0;
      tick(2);

      send_start(8'h55, 0);
      dev_run(4, 0, 0, bits, hi, rq);
      check("mid_bits", bits[4:0], 5'b01010);
      check("mid_data_oe", ps2_data_oe, 1);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_clk_oe", ps2_clk_oe, 0);
      check("mid_rst_data_oe", ps2_data_oe, 0);
      tick(2);
      reset = 1'b0;
      tick(1);
      check("mid_rst_ready", tx_ready, 1);
      send_start(8'h00, 0);
      dev_run(11, 0, 0, bits, hi, rq);
      check("zero_frame", bits, {1'b1, 1'b1, 8'h00, 1'b0});
      end_frame("zero", 0);

      d0 = done_cnt;
      t0 = ackerr_cnt;
      send_start(8'hF4, 0);
      dev_run(11, 0, 0, bits, hi, rq);
      check("f4_clk_oe_len", hi, 24);
      check("f4_req_len", rq, 4);
      check("f4_frame", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
      end_frame("f4", 0);
      check("f4_done_cnt", done_cnt - d0, 1);
      check("f4_no_ack_err", ackerr_cnt - t0, 0);

      send_start(8'hED, 0);
      dev_run(11, 1, 0, bits, hi, rq);
      check("ed_parity", bits[9], 1);
      check("ed_frame", bits, {1'b1, 1'b1, 8'hED, 1'b0});
      end_frame("ed", 1);
      check("ed_ack_coincident", stray_ack, 0);

      d0 = done_cnt;
      t0 = tmo_cnt;
      send_start(8'hA5, 0);
      dev_run(5, 0, 0, bits, hi, rq);
      check("tmo_bits", bits[5:0], 6'b001010);
      n = 0;
      while (!timeout_err && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("tmo_window", (2 * HALF + n >= 502) && (2 * HALF + n <= 504), 1);
      check("tmo_clk_oe", ps2_clk_oe, 0);
      check("tmo_data_oe", ps2_data_oe, 0);
      check("tmo_ready", tx_ready, 1);
      @(negedge clk);
      check("tmo_pulse", timeout_err, 0);
      check("tmo_count", tmo_cnt - t0, 1);
      check("tmo_no_done", done_cnt - d0, 0);

      a0 = acc_cnt;
      send_start(8'hFF, 1);
      tx_data = 8'h01;
      dev_run(11, 0, 0, bits, hi, rq);
      check("b2b_busy_ignored", acc_cnt - a0, 1);
      check("b2b_ff_frame", bits, {1'b1, 1'b1, 8'hFF, 1'b0});
      end_frame("b2b_ff", 0);
      @(negedge clk);
      check("b2b_second_accept", tx_ready, 0);
      tx_valid = 1'b0;
      check("b2b_acc2", acc_cnt - a0, 2);
      dev_run(11, 0, 0, bits, hi, rq);
      check("b2b_clk_oe_len", hi, 24);
      check("b2b_01_frame", bits, {1'b1, 1'b0, 8'h01, 1'b0});
      end_frame("b2b_01", 0);
      check("b2b_acc_final", acc_cnt - a0, 2);

      d0 = done_cnt;
      send_start(8'hF4, 0);
      watch_rx = 1'b1;
      dev_run(11, 0, 100, bits, hi, rq);
      check("hold_no_early_done", done_at_rel - d0, 0);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      watch_rx = 1'b0;
      check("hold_done_lat", n, 3);
      check("hold_rx_block", rx_drop, 0);
      check("hold_ack_err", ack_err, 0);
      @(negedge clk);
      check("hold_ready", tx_ready, 1);
      check("hold_rx_release", rx_block, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the same open-collector ps2_clk/ps2_data pair that the PS/2 receiver listens on. It runs the bus-request sequence, shifts out the frame on device-generated clock edges, checks the device ACK, and reports completion or error. It sits next to the PS/2 receiver in the top level and drives `rx_block` so the receiver ignores the transmitted frame.

## Interface
- `INHIBIT_CYCLES`, 12000: clk cycles ps2_clk is held low before the request (120 µs at 100 MHz).
- `SETUP_CYCLES`, 200: clk cycles data and clock are both held low before clock is released.
- `TIMEOUT_CYCLES`, 2000000: maximum clk cycles between device clock falling edges, or in WAIT_IDLE, before abort (20 ms).
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `tx_data` in 8: command byte.
- `tx_valid` in 1: request to send; accepted when `tx_valid & tx_ready`.
- `tx_ready` out 1: high only in IDLE.
- `ps2_clk_in` in 1: raw PS/2 clock line (asynchronous).
- `ps2_data_in` in 1: raw PS/2 data line (asynchronous).
- `ps2_clk_oe` out 1: 1 = pull clock line low; 0 = release.
- `ps2_data_oe` out 1: 1 = pull data line low; 0 = release.
- `rx_block` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a frame completes.
- `ack_err` out 1: one-cycle pulse, coincident with `done`, if the sampled ACK is 1.
- `timeout_err` out 1: one-cycle pulse on abort; `done` stays low.

## Operation
- Inputs pass through 2-FF synchronizers; a falling edge is synced-previous=1 and synced-current=0.
- On accept, latch `tx_data` and build a 10-bit shift register {stop=1, parity=~^tx_data, data[7:0]}; parity is odd.
- States:
  - IDLE: both oe = 0.
  - INHIBIT: `ps2_clk_oe` = 1 for INHIBIT_CYCLES.
  - REQUEST: both oe = 1 for SETUP_CYCLES. This drives the start bit.
  - SEND: `ps2_clk_oe` = 0, `ps2_data_oe` held at 1 until the first falling edge. On falling edges 1..10 set `ps2_data_oe` = ~shift[0] and shift right. Edges 1–8 send data LSB first, edge 9 sends parity, edge 10 sends stop (line released).
  - ACK: on the 11th falling edge sample synced data; 0 = ACK good.
  - WAIT_IDLE: wait until synced clock and data are both 1.
  - DONE: pulse `done` (plus `ack_err` if the ACK was 1), then IDLE.
- Timeout counter clears on entry to SEND and on every falling edge in SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: release both lines, pulse `timeout_err`, go to IDLE.
- `tx_valid` outside IDLE is ignored. There is no queue.
- Counter widths are `$clog2(param+1)`. Counters never wrap.

## Timing
- Reset values: state IDLE, `tx_ready` = 1, both oe = 0, `rx_block` = 0, `done`, `ack_err`, `timeout_err` = 0. Lines are released asynchronously on `reset` assertion, including mid-frame.
- All outputs are registered.
- `tx_ready` falls the cycle after accept, and `ps2_clk_oe` rises in that same cycle.
- `ps2_clk_oe` is high for exactly INHIBIT_CYCLES + SETUP_CYCLES cycles. `ps2_data_oe` rises on the first REQUEST cycle.
- `ps2_data_oe` updates 3 clk cycles after a raw ps2_clk falling edge: 2 sync stages plus 1 output register.
- `done` asserts the cycle after both synced lines read high in WAIT_IDLE. `tx_ready` returns 1 the following cycle.
- If a falling edge and the timeout terminal count occur in the same cycle, the edge wins and the counter clears.
- The bus is never driven in ACK or WAIT_IDLE.

## Test plan
Bench uses INHIBIT_CYCLES=20, SETUP_CYCLES=4, TIMEOUT_CYCLES=500, with a device model clocking at 40 clk cycles per half period.
- Reset mid-SEND (after 4 edges): both oe drop to 0 immediately; `tx_ready`=1 after release; a new send of 0x00 then completes with parity bit 1.
- Send 0xF4, ACK=0: `ps2_clk_oe` high for 24 cycles; device reads start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1; one `done` pulse, `ack_err`=0.
- Send 0xED with the device returning ACK=1: parity 1 is observed on the line; `done` and `ack_err` pulse in the same cycle.
- Device stops clocking after 5 edges: `timeout_err` pulses 500 cycles after the 5th synced edge; lines are released; `done` never pulses.
- `tx_valid` held high with 0xFF then 0x01 back-to-back: the second byte is accepted only after `done`; device reads 0xFF with parity 1, then 0x01 with parity 0; `tx_valid` during the busy period has no effect.
- Device holds data low after the ACK for 100 cycles: `done` is delayed until data goes high; `rx_block` stays 1 throughout.
